// File: rtl/mux_sweep_pkg.sv
// Shared types and constants for the mux sweep driver.
package mux_sweep_pkg;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned IW_W     = 18;
    localparam int unsigned OW_W     = 24;
    localparam int unsigned PAT_W    = 5;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned NUM_ADDR = 32;
    localparam int unsigned NUM_PAT  = 19;

    localparam logic [OW_W-1:0] DEFAULT_POLY = 24'h00001B;
    localparam logic [OW_W-1:0] DEFAULT_SEED = 24'hFFFFFF;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StSample,
        StEmit,
        StDone
    } sweep_state_e;

    // Pattern 0 is all-zero; pattern k>=1 is a single one at bit k-1.
    function automatic logic [IW_W-1:0] pat_to_iw(input logic [PAT_W-1:0] pat);
        pat_to_iw = '0;
        if (pat != '0) begin
            pat_to_iw = IW_W'(1) << (pat - PAT_W'(1));
        end
    endfunction

endpackage

// File: rtl/mux_sweep_misr.sv
// 24-bit multiple-input signature register: seed on load, fold one sample per shift.
module mux_sweep_misr
    import mux_sweep_pkg::*;
#(
    parameter logic [OW_W-1:0] POLY = DEFAULT_POLY,
    parameter logic [OW_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            shift_i,
    input  logic [OW_W-1:0] data_i,
    output logic [OW_W-1:0] sig_o
);

    logic [OW_W-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load_i) begin
            sig_d = SEED;
        end else if (shift_i) begin
            sig_d = {sig_q[OW_W-2:0], 1'b0} ^ (sig_q[OW_W-1] ? POLY : '0) ^ data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/mux_sweep_driver.sv
// Sweeps every mux address against zero + walking-one patterns and folds ow into a MISR.
// Define MUX_SWEEP_CAPTURE_EN to add a per-step capture handshake (cap_valid/cap_ready/cap_data).
module mux_sweep_driver
    import mux_sweep_pkg::*;
#(
    parameter int unsigned      SETTLE = 4,
    parameter logic [OW_W-1:0]  POLY   = DEFAULT_POLY,
    parameter logic [OW_W-1:0]  SEED   = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr_o,
    output logic [IW_W-1:0]   iw_o,
    input  logic [OW_W-1:0]   ow_i,
    output logic [OW_W-1:0]   signature
`ifdef MUX_SWEEP_CAPTURE_EN
    ,
    output logic              cap_valid,
    input  logic              cap_ready,
    output logic [33:0]       cap_data
`endif
);

    localparam logic [CNT_W-1:0]  SettleLast = CNT_W'(SETTLE - 1);
    localparam logic [ADDR_W-1:0] AddrLast   = ADDR_W'(NUM_ADDR - 1);
    localparam logic [PAT_W-1:0]  PatLast    = PAT_W'(NUM_PAT - 1);

    sweep_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic              misr_load, misr_shift, advance;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        pat_d      = pat_q;
        misr_load  = 1'b0;
        misr_shift = 1'b0;
        advance    = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StDrive;
                    cnt_d     = '0;
                    addr_d    = '0;
                    pat_d     = '0;
                    misr_load = 1'b1;
                end
            end
            StDrive: begin
                if (cnt_q == SettleLast) begin
                    state_d = StSample;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StSample: begin
                misr_shift = 1'b1;
`ifdef MUX_SWEEP_CAPTURE_EN
                state_d = StEmit;
`else
                advance = 1'b1;
`endif
            end
`ifdef MUX_SWEEP_CAPTURE_EN
            StEmit: advance = cap_ready;
`endif
            default: state_d = StIdle;
        endcase

        // Step order: pattern inner, address outer; stop after the last step.
        if (advance) begin
            if (addr_q == AddrLast && pat_q == PatLast) begin
                state_d = StDone;
            end else begin
                state_d = StDrive;
                if (pat_q == PatLast) begin
                    pat_d  = '0;
                    addr_d = addr_q + ADDR_W'(1);
                end else begin
                    pat_d = pat_q + PAT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            pat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            pat_q   <= pat_d;
        end
    end

    mux_sweep_misr #(
        .POLY (POLY),
        .SEED (SEED)
    ) u_misr (
        .clk     (clk),
        .rst     (rst),
        .load_i  (misr_load),
        .shift_i (misr_shift),
        .data_i  (ow_i),
        .sig_o   (signature)
    );

    assign busy   = (state_q == StDrive) || (state_q == StSample) || (state_q == StEmit);
    assign done   = (state_q == StDone);
    assign addr_o = addr_q;
    assign iw_o   = pat_to_iw(pat_q);

`ifdef MUX_SWEEP_CAPTURE_EN
    logic [OW_W-1:0] cap_ow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_ow_q <= '0;
        end else if (misr_shift) begin
            cap_ow_q <= ow_i;
        end
    end

    assign cap_valid = (state_q == StEmit);
    assign cap_data  = {addr_q, pat_q, cap_ow_q};
`endif

endmodule
